// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants, opcodes and fetch FSM state type for the MIPS core.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   localparam logic [5:0]  OP_J      = 6'b000010;
   localparam logic [5:0]  OP_BEQ    = 6'b000100;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   // J-type target: upper nibble of PC+4, 26-bit word index, word aligned.
   function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                               input logic [25:0] word_idx);
      return {pc4_hi, word_idx, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register (instr, pc4, valid) with hold and flush.
// Revision : 1.0
// ============================================================================
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_hold,
   input  logic        i_flush,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;

   // A flush turns the slot into a bubble but leaves pc4 untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (!i_hold) begin
         r_instr <= i_instr;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : IF stage: PC, next-PC mux, fetch FSM, IF/ID register, fetch counter.
//            Optional fetch-address fault checking under macro FETCH_FAULT_EN.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
   parameter int          IMEM_DEPTH = 32,
   parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic        fetch_fault
);

   import cpu_pkg::*;

   localparam logic [31:0] c_imem_bytes = 32'(IMEM_DEPTH * 4);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] w_pc4;
   logic [31:0] w_jump_pc;
   logic [31:0] r_fetch_count;
   logic        w_load;
   logic        w_flush;
   logic        w_fault_cond;
   logic        w_fault_hit;

   assign w_pc4        = r_pc + 32'd4;
   assign w_jump_pc    = jump_target(if_id_pc4[31:28], if_id_instr[25:0]);
   assign w_fault_cond = (r_pc[1:0] != 2'b00) || (r_pc >= c_imem_bytes);

`ifdef FETCH_FAULT_EN
   // Redirects and stalls outrank the fault check; only a plain fetch can fault.
   assign w_fault_hit = (r_state == RUN) & w_fault_cond & ~stall & ~branch_taken & ~jump;
`else
   logic w_unused;
   assign w_fault_hit = 1'b0;
   assign w_unused    = w_fault_cond;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         BOOT:    w_state_next = RUN;
         RUN:     if (w_fault_hit) w_state_next = FAULT;
         default: w_state_next = r_state;
      endcase
   end

   always_comb begin
      w_pc_next = r_pc;
      w_load    = 1'b0;
      w_flush   = 1'b0;
      case (r_state)
         RUN: begin
            if (!stall) begin
               if (branch_taken) begin
                  w_pc_next = branch_target;
                  w_flush   = 1'b1;
               end else if (jump) begin
                  w_pc_next = w_jump_pc;
                  w_flush   = 1'b1;
               end else if (w_fault_hit) begin
                  w_flush   = 1'b1;
               end else begin
                  w_pc_next = w_pc4;
                  w_load    = 1'b1;
               end
            end
         end
         FAULT:   w_flush = 1'b1;
         default: w_flush = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_fetch_count <= 32'd0;
      end else begin
         r_pc <= w_pc_next;
         if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

`ifdef FETCH_FAULT_EN
   logic r_fault;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else if (w_fault_hit) begin
         r_fault <= 1'b1;
      end
   end

   assign fetch_fault = r_fault;
`else
   assign fetch_fault = 1'b0;
`endif

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk     (clk),
      .rst     (reset),
      .i_hold  (~w_load),
      .i_flush (w_flush),
      .i_instr (imem_instr),
      .i_pc4   (w_pc4),
      .o_instr (if_id_instr),
      .o_pc4   (if_id_pc4),
      .o_valid (if_id_valid)
   );

   assign imem_addr   = r_pc;
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
